// File: rtl/ntsc_pkg.sv
// Shared types and constants for the NTSC line fetcher and the composite generator.
package ntsc_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    localparam int PIX_BITS     = 4;
    localparam int PIX_PER_WORD = 4;
    localparam int WORD_BITS    = PIX_BITS * PIX_PER_WORD;

    localparam int WORDS_PER_LINE_DEF = 64;
    localparam int V_LINES_DEF        = 240;
    localparam int MAX_LEVEL_DEF      = 12;

    // Codes above MAX_LEVEL are reserved by the generator; sync is one of them.
    localparam logic [PIX_BITS-1:0] LUMA_BLACK = 4'd0;
    localparam logic [PIX_BITS-1:0] LUMA_SYNC  = 4'd15;

    // Pixels are packed MSB-first: column 0 of a word sits in bits 15:12.
    function automatic logic [PIX_BITS-1:0] nibble_sel(input logic [WORD_BITS-1:0] word,
                                                       input logic [1:0]           sel);
        logic [PIX_BITS-1:0] nib;
        case (sel)
            2'd0:    nib = word[15:12];
            2'd1:    nib = word[11:8];
            2'd2:    nib = word[7:4];
            default: nib = word[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/ntsc_line_fetch_if.sv
// Line timing, pixel request, memory read bus and status signals of the line fetcher.
interface ntsc_line_fetch_if;

    logic        line_start;
    logic [8:0]  line_y;
    logic [15:0] fb_base;
    logic        pix_en;
    logic [7:0]  pix_x;
    logic [3:0]  pix_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        underrun_clr;
    logic        underrun;

    modport master (
        input  line_start, line_y, fb_base, pix_en, pix_x, mem_ack, mem_data, underrun_clr,
        output pix_data, mem_req, mem_addr, underrun
    );

    modport slave (
        output line_start, line_y, fb_base, pix_en, pix_x, mem_ack, mem_data, underrun_clr,
        input  pix_data, mem_req, mem_addr, underrun
    );

endinterface

// File: rtl/line_buffer_2bank.sv
// Two-bank line RAM: one synchronous write port and one registered read port.
module line_buffer_2bank
    import ntsc_pkg::*;
#(
    parameter int WORDS = WORDS_PER_LINE_DEF,
    parameter int IDX_W = $clog2(WORDS_PER_LINE_DEF)
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic                 wr_bank_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [WORD_BITS-1:0] wr_data_i,
    input  logic                 rd_bank_i,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output logic [WORD_BITS-1:0] rd_data_o
);

    logic [WORD_BITS-1:0] mem_q [2*WORDS];
    logic [WORD_BITS-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[{wr_bank_i, wr_idx_i}] <= wr_data_i;
        end
        rd_data_q <= mem_q[{rd_bank_i, rd_idx_i}];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ntsc_line_fetch.sv
// Fetches the next scanline into the off-screen bank while the on-screen bank feeds
// clamped luma pixels to the composite generator.
module ntsc_line_fetch
    import ntsc_pkg::*;
#(
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    parameter int V_LINES        = V_LINES_DEF,
    parameter int MAX_LEVEL      = MAX_LEVEL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    ntsc_line_fetch_if.master bus
);

    localparam int                  IDX_W    = $clog2(WORDS_PER_LINE);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);
    localparam logic [PIX_BITS-1:0] MAX_CODE = PIX_BITS'(MAX_LEVEL);

    function automatic logic [PIX_BITS-1:0] luma_clamp(input logic [PIX_BITS-1:0] code);
        return (code > MAX_CODE) ? MAX_CODE : code;
    endfunction

    fetch_state_e         state_q, state_d;
    logic                 disp_bank_q, disp_bank_d;
    logic [1:0]           bank_valid_q, bank_valid_d;
    logic [IDX_W-1:0]     word_idx_q, word_idx_d;
    logic [WORD_BITS-1:0] mem_addr_q, mem_addr_d;
    logic                 underrun_q, underrun_d;
    logic                 pix_vld_q, pix_vld_d;
    logic [1:0]           nib_sel_q;

    logic                 fetch_bank;
    logic                 rd_bank;
    logic                 line_in_range;
    logic                 take_ack;
    logic                 last_word;
    logic [WORD_BITS-1:0] line_base;
    logic [WORD_BITS-1:0] rd_word;
    logic                 mem_req;
    logic [PIX_BITS-1:0]  pix_data;

    assign fetch_bank    = ~disp_bank_q;
    // A pixel read in the swap cycle must already see the bank about to be displayed.
    assign rd_bank       = bus.line_start ? fetch_bank : disp_bank_q;
    assign line_in_range = int'(bus.line_y) < V_LINES;
    assign line_base     = bus.fb_base + WORD_BITS'(int'(bus.line_y) * WORDS_PER_LINE);
    assign take_ack      = (state_q == ST_FETCH) && bus.mem_ack && !bus.line_start;
    assign last_word     = (word_idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.line_start) begin
            state_d = line_in_range ? ST_FETCH : ST_IDLE;
        end else if (take_ack && last_word) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        mem_req  = (state_q == ST_FETCH);
        pix_data = pix_vld_q ? luma_clamp(nibble_sel(rd_word, nib_sel_q)) : LUMA_BLACK;
    end

    always_comb begin
        disp_bank_d  = disp_bank_q;
        bank_valid_d = bank_valid_q;
        word_idx_d   = word_idx_q;
        mem_addr_d   = mem_addr_q;
        underrun_d   = underrun_q;
        pix_vld_d    = bus.pix_en && bank_valid_q[rd_bank];

        if (bus.line_start) begin
            disp_bank_d               = fetch_bank;
            bank_valid_d[disp_bank_q] = 1'b0;
            word_idx_d                = '0;
            if (line_in_range) begin
                mem_addr_d = line_base;
            end
        end else if (take_ack) begin
            word_idx_d = word_idx_q + 1'b1;
            // Address stays on the final word once the line is complete.
            if (last_word) begin
                bank_valid_d[fetch_bank] = 1'b1;
            end else begin
                mem_addr_d = mem_addr_q + 16'd1;
            end
        end

        // A new underrun wins over a simultaneous clear.
        if (bus.line_start && (state_q == ST_FETCH)) begin
            underrun_d = 1'b1;
        end else if (bus.underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_bank_q  <= 1'b0;
            bank_valid_q <= 2'b00;
            word_idx_q   <= '0;
            mem_addr_q   <= '0;
            underrun_q   <= 1'b0;
            pix_vld_q    <= 1'b0;
        end else begin
            disp_bank_q  <= disp_bank_d;
            bank_valid_q <= bank_valid_d;
            word_idx_q   <= word_idx_d;
            mem_addr_q   <= mem_addr_d;
            underrun_q   <= underrun_d;
            pix_vld_q    <= pix_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        nib_sel_q <= bus.pix_x[1:0];
    end

    line_buffer_2bank #(
        .WORDS (WORDS_PER_LINE),
        .IDX_W (IDX_W)
    ) u_line_buffer (
        .clk       (clk),
        .wr_en_i   (take_ack),
        .wr_bank_i (fetch_bank),
        .wr_idx_i  (word_idx_q),
        .wr_data_i (bus.mem_data),
        .rd_bank_i (rd_bank),
        .rd_idx_i  (IDX_W'(bus.pix_x[7:2])),
        .rd_data_o (rd_word)
    );

    assign bus.mem_req  = mem_req;
    assign bus.mem_addr = mem_addr_q;
    assign bus.pix_data = pix_data;
    assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_ntsc_line_fetch.sv
// Directed and randomized bench for ntsc_line_fetch with a line-level reference model.
module tb_ntsc_line_fetch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntsc_line_fetch_if bus ();

    ntsc_line_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc    = 0;
    int ack_period = 1;
    int data_mode  = 0;   // 0: data = address, 1: random, 2: random with 0xF5AC at word 0
    bit force_ack  = 1'b0;

    // Reference model: what each bank holds, which banks are complete, and the fetch in flight.
    logic [15:0] m_bank [2][64];
    bit          m_valid [2];
    bit          m_disp;
    bit          m_fetching;
    bit          m_underrun;
    int          m_idx;
    logic [15:0] m_base;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_pixel(input logic [15:0] w, input int s);
        int n;
        n = int'((w >> (12 - 4 * s)) & 16'h000F);
        return (n > 12) ? 4'd12 : 4'(n);
    endfunction

    task automatic step();
        logic        ack;
        logic [15:0] data;
        logic [3:0]  exp_pix;
        bit          nd;

        ack = force_ack || ((bus.mem_req === 1'b1) && ((cyc % ack_period) == 0));
        if (data_mode == 0)                        data = bus.mem_addr;
        else if (data_mode == 2 && m_idx == 0)     data = 16'hF5AC;
        else                                       data = 16'($urandom);
        bus.mem_ack  = ack;
        bus.mem_data = data;

        if (m_fetching && !rst) check("mem_addr", bus.mem_addr, m_base + 16'(m_idx));

        nd = bus.line_start ? !m_disp : m_disp;
        if (!rst && bus.pix_en && m_valid[nd])
            exp_pix = exp_pixel(m_bank[nd][bus.pix_x[7:2]], int'(bus.pix_x[1:0]));
        else
            exp_pix = 4'd0;

        if (rst) begin
            m_fetching = 1'b0; m_disp = 1'b0; m_valid[0] = 1'b0; m_valid[1] = 1'b0;
            m_idx = 0; m_underrun = 1'b0;
        end else if (bus.line_start) begin
            if (m_fetching) m_underrun = 1'b1;
            else if (bus.underrun_clr) m_underrun = 1'b0;
            m_valid[m_disp] = 1'b0;
            m_disp     = !m_disp;
            m_idx      = 0;
            m_fetching = (int'(bus.line_y) < 240);
            m_base     = bus.fb_base + 16'(int'(bus.line_y) * 64);
        end else begin
            if (bus.underrun_clr) m_underrun = 1'b0;
            if (m_fetching && ack) begin
                m_bank[!m_disp][m_idx] = data;
                m_idx++;
                if (m_idx == 64) begin
                    m_valid[!m_disp] = 1'b1;
                    m_fetching = 1'b0;
                end
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        bus.mem_ack      = 1'b0;
        bus.line_start   = 1'b0;
        bus.underrun_clr = 1'b0;
        force_ack        = 1'b0;

        check("mem_req", 16'(bus.mem_req), 16'(m_fetching));
        check("underrun", 16'(bus.underrun), 16'(m_underrun));
        check("pix_data", 16'(bus.pix_data), 16'(exp_pix));
    endtask

    task automatic rand_pix();
        bus.pix_en = ($urandom_range(0, 3) != 0);
        bus.pix_x  = 8'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            rand_pix();
            step();
        end
    endtask

    task automatic new_line(input logic [8:0] y, input logic [15:0] base);
        bus.line_y     = y;
        bus.fb_base    = base;
        bus.line_start = 1'b1;
        rand_pix();
        step();
    endtask

    task automatic pix_at(input string tag, input logic [7:0] x, input logic [3:0] exp);
        bus.pix_en = 1'b1;
        bus.pix_x  = x;
        step();
        check(tag, 16'(bus.pix_data), 16'(exp));
    endtask

    initial begin
        bus.line_start = 1'b0; bus.line_y = '0; bus.fb_base = '0;
        bus.pix_en = 1'b0; bus.pix_x = '0; bus.mem_ack = 1'b0; bus.mem_data = '0;
        bus.underrun_clr = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        check("reset_mem_addr", bus.mem_addr, 16'h0000);
        rst = 1'b0;

        // No line fetched yet: every column reads as zero.
        for (int x = 0; x < 256; x++) begin
            bus.pix_en = 1'b1;
            bus.pix_x  = 8'(x);
            step();
        end

        // Line A: data equals address.
        ack_period = 1; data_mode = 0;
        new_line(9'd2, 16'h1000);
        check("first_addr", bus.mem_addr, 16'h1080);
        run(70);
        check("last_addr", bus.mem_addr, 16'h10BF);

        // Line B fetch while A is displayed.
        data_mode = 2;
        new_line(9'd5, 16'h2000);
        pix_at("pix_x4", 8'd4, 4'd1);
        pix_at("pix_x7", 8'd7, 4'd1);
        run(70);

        // Line C fetch while B (word 0 = 0xF5AC) is displayed.
        data_mode = 1;
        new_line(9'd7, 16'h3000);
        pix_at("pix_x0_clamp", 8'd0, 4'd12);
        pix_at("pix_x1", 8'd1, 4'd5);
        pix_at("pix_x2", 8'd2, 4'd10);
        pix_at("pix_x3_clamp", 8'd3, 4'd12);
        run(70);

        // Slow memory: the fetch of line D cannot finish.
        ack_period = 20;
        new_line(9'd20, 16'h4000);
        run(205);
        new_line(9'd21, 16'h4000);
        check("underrun_set", 16'(bus.underrun), 16'h1);
        pix_at("incomplete_bank", 8'($urandom), 4'd0);
        bus.underrun_clr = 1'b1;
        rand_pix();
        step();
        check("underrun_clr", 16'(bus.underrun), 16'h0);
        bus.underrun_clr = 1'b1;
        new_line(9'd22, 16'h4000);
        check("set_beats_clr", 16'(bus.underrun), 16'h1);

        // Abandon a fast fetch mid-line with an ack in the swap cycle.
        ack_period = 1;
        run(30);
        new_line(9'd30, 16'h5000);
        run(70);
        bus.underrun_clr = 1'b1;
        run(1);

        // Address wraps at 16 bits.
        new_line(9'd0, 16'hFFF0);
        run(15);
        check("wrap_ffff", bus.mem_addr, 16'hFFFF);
        run(1);
        check("wrap_0000", bus.mem_addr, 16'h0000);
        run(60);

        // Line beyond the framebuffer: no request, then a blank displayed line.
        new_line(9'd240, 16'h0100);
        check("no_req_240", 16'(bus.mem_req), 16'h0);
        run(20);
        new_line(9'd10, 16'h0500);
        pix_at("blank_line", 8'($urandom), 4'd0);

        // Reset in the middle of a fetch, then a late ack.
        ack_period = 3;
        run(30);
        rst = 1'b1;
        run(1);
        check("rst_req_drop", 16'(bus.mem_req), 16'h0);
        rst = 1'b0;
        force_ack = 1'b1;
        run(1);
        run(5);

        // Randomized lines, memory pacing and underrun clears.
        for (int l = 0; l < 10; l++) begin
            ack_period = $urandom_range(1, 2);
            new_line(9'($urandom_range(0, 250)), 16'($urandom));
            for (int i = 0; i < int'($urandom_range(60, 140)); i++) begin
                rand_pix();
                if ($urandom_range(0, 15) == 0) bus.underrun_clr = 1'b1;
                step();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
